acc_timer_array: RTL

ACC_TIMER_ARRAY -- requirements
Module: acc_timer_array

---
 rtl/acc_timer_array.sv | 130 +++++++++++++
 1 files changed

// File: rtl/acc_timer_array.sv
// Array of independent down-counting timers. Each channel is a small IDLE/RUN FSM with
// one-shot or auto-reload behaviour, abort, and a sticky overrun flag.
module acc_timer_array #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int DEF_LEN = 50000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       i_start,
  input  logic [NUM_CH-1:0]       i_abort,
  input  logic [NUM_CH-1:0]       i_periodic,
  input  logic [NUM_CH*CNT_W-1:0] i_len,
  input  logic [NUM_CH-1:0]       i_clr_ovr,
  output logic [NUM_CH-1:0]       o_busy,
  output logic [NUM_CH-1:0]       o_finish,
  output logic [NUM_CH-1:0]       o_ovr
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DEF_LEN_W = CNT_W'(DEF_LEN);
  localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_W    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONES_W    = {CNT_W{1'b1}};

  // Zero length behaves as a single cycle; all-ones selects the legacy default tick.
  function automatic logic [CNT_W-1:0] f_neff(input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] neff;
    if (len == ZERO_W) begin
      neff = ONE_W;
    end else if (len == ONES_W) begin
      neff = DEF_LEN_W;
    end else begin
      neff = len;
    end
    return neff;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_neff;
    logic             r_busy;
    logic             r_finish;
    logic             w_finish_nxt;
    logic             r_ovr;
    logic             w_ovr_nxt;
    logic             w_ovr_set;

    assign w_neff = f_neff(i_len[c*CNT_W +: CNT_W]);

    // Next-state and counter logic; abort takes priority over expiry.
    always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_finish_nxt = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start[c] && !i_abort[c]) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = w_neff;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (i_abort[c]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = ZERO_W;
          end else if (r_cnt == ONE_W) begin
            w_finish_nxt = 1'b1;
            if (i_periodic[c]) begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = w_neff;
            end else begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = ZERO_W;
            end
          end else begin
            w_cnt_nxt = r_cnt - ONE_W;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = ZERO_W;
        end
      endcase
    end

    // Any start seen while running is an overrun, including on the expiry edge.
    always_comb begin
      w_ovr_set = (r_state == ST_RUN) && i_start[c];
      if (w_ovr_set) begin
        w_ovr_nxt = 1'b1;
      end else if (i_clr_ovr[c]) begin
        w_ovr_nxt = 1'b0;
      end else begin
        w_ovr_nxt = r_ovr;
      end
    end

    // Channel state and output flops.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state  <= ST_IDLE;
        r_cnt    <= ZERO_W;
        r_busy   <= 1'b0;
        r_finish <= 1'b0;
        r_ovr    <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_busy   <= (w_state_nxt == ST_RUN);
        r_finish <= w_finish_nxt;
        r_ovr    <= w_ovr_nxt;
      end
    end

    assign o_busy[c]   = r_busy;
    assign o_finish[c] = r_finish;
    assign o_ovr[c]    = r_ovr;
  end

endmodule
